audio_sample_fifo: RTL
======================

Name: audio_sample_fifo

Overview:
- Sample buffer stage directly upstream of the WM8731 codec top.
- Accepts 16-bit PCM samples from the synth voice path over a valid/ready handshake and stores them in a small FIFO.
- Presents one sample on the codec's 16-bit audio input, advancing by one sample each time the codec signals consumption via its myvalid strobe.
- Handles prefill, underrun recovery and mute.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2 = 16 entries).
- DATA_W, 16, sample width, two's complement.
- PREFILL, 8, entries required before playback starts or resumes (1..DEPTH).

Ports:
- clk_50m  in  1  system clock, 50 MHz; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_data  in  DATA_W  sample from synth.
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO can accept; transfer when s_valid & s_ready at a rising edge.
- myvalid  in  1  consumption strobe from codec top, clk_50m domain, may stay high for several cycles.
- mute  in  1  level; forces zero output while high.
- audio_out  out  DATA_W  sample driven to codec audio input.
- level  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH.
- underrun  out  1  one-cycle pulse on underrun.

Behaviour:
- Reset (async assert, sync deassert release inside the block):
  - audio_out=0, level=0, underrun=0, s_ready=1.
  - Pointers=0, myvalid_d=0, state=FILL.
  - FIFO contents are don't-care.
- Request detect: req = myvalid & ~myvalid_d, with myvalid_d registered. Exactly one req per myvalid high period.
- Push:
  - Occurs when s_valid & s_ready.
  - Writes mem[wr_ptr]; wr_ptr wraps modulo DEPTH.
  - s_ready = (level != DEPTH), registered-equivalent, no combinational path from myvalid.
- Full:
  - s_ready=0.
  - A same-cycle pop does NOT allow a push; the producer must retry next cycle.
- State machine, 2 states:
  - FILL:
    - req → audio_out<=0, no pop, no underrun pulse.
    - FILL→RUN when level >= PREFILL, evaluated on the registered level at each edge.
  - RUN, req with level>0:
    - Pop mem[rd_ptr] into audio_out (zero if mute=1; pop still occurs).
    - rd_ptr wraps modulo DEPTH.
  - RUN, req with level==0:
    - audio_out<=0, underrun=1 for one cycle, RUN→FILL.
- Latency: myvalid rising at edge N (seen high, myvalid_d low) → audio_out and level updated at edge N+1.
- level arithmetic:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop.
  - Never exceeds DEPTH or goes below 0.
- Empty with simultaneous push and req (RUN):
  - Counts as underrun; no bypass.
  - Pushed sample is stored, level becomes 1.
- audio_out holds its value between reqs. A mute change takes effect on the next req only; there is no glitch mid-sample.
- Reset mid-operation: all state returns to reset values immediately. Pending samples are discarded; the next req outputs 0 (FILL).

Optional Feature:
- Macro AUDIO_FIFO_STATS_EN.
- When defined:
  - Adds output ports underrun_cnt (16) and overrun_cnt (16), both reset to 0 and saturating at 0xFFFF.
  - underrun_cnt increments on each underrun pulse.
  - overrun_cnt increments on each cycle with s_valid & ~s_ready.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Prefill: reset, push 8 samples 0x0001..0x0008, then pulse myvalid (3 cycles high) → a req before level reaches 8 gives audio_out=0x0000; after 8 pushes, the first req gives 0x0001 at edge N+1 and level=7; one req per high period.
- Full/back-pressure: hold s_valid=1 with incrementing data and no req → level=16, s_ready=0, data 17+ not stored. With AUDIO_FIFO_STATS_EN, overrun_cnt counts the stalled cycles. Next 16 reqs return data 1..16 in order, crossing pointer wrap.
- Underrun: in RUN with level=1, issue 2 reqs → first returns the stored sample; second gives audio_out=0, one-cycle underrun pulse, state FILL. Subsequent reqs output 0 until level>=8.
- Simultaneous: level=4 in RUN, push and req on the same edge → level stays 4, audio_out=oldest sample. With level=0, push+req → underrun pulse, level=1.
- Mute: RUN with samples 0x7FFF,0x8000, mute=1 during the first req, 0 during the second → audio_out 0x0000 then 0x8000; level decrements by 2.
- Async reset: assert rst mid-stream between edges → audio_out=0, level=0, s_ready=1 before the next clock edge; the first req after release outputs 0.

Source files
------------

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: 16-entry PCM sample buffer feeding the WM8731 codec top.
// Ports: clk_50m/rst, s_data/s_valid/s_ready in, myvalid/mute, audio_out/level/underrun out.
// Optional AUDIO_FIFO_STATS_EN adds underrun_cnt/overrun_cnt saturating counters.
module audio_sample_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int DATA_W     = 16,
  parameter int PREFILL    = 8
) (
  input  logic                  clk_50m,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  myvalid,
  input  logic                  mute,
  output logic [DATA_W-1:0]     audio_out,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  underrun
`ifdef AUDIO_FIFO_STATS_EN
  ,
  output logic [15:0]           underrun_cnt,
  output logic [15:0]           overrun_cnt
`endif
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam int LW    = DEPTH_LOG2 + 1;

  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_PRE  = LW'(PREFILL);

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Reset asserts asynchronously but releases on a clock edge,
  // so no flop sees rst fall close to its sampling edge.
  logic [1:0] rst_sync;
  logic       rst_i;

  always_ff @(posedge clk_50m or posedge rst) begin
    if (rst) begin
      rst_sync <= 2'b11;
    end else begin
      rst_sync <= {rst_sync[0], 1'b0};
    end
  end

  assign rst_i = rst_sync[1];

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [0:0]            state;
  logic [0:0]            state_nxt;
  logic                  myvalid_d;
  logic [LW-1:0]         level_nxt;
  logic [DATA_W-1:0]     out_nxt;

  logic full;
  logic empty;
  logic is_run;
  logic push;
  logic req;
  logic pop;
  logic under_ev;
  logic fill_req;

  // s_ready depends only on the level register; a pop in the
  // same cycle never opens a slot for the producer.
  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign s_ready = ~full;
  assign push    = s_valid & s_ready;

  // One request per myvalid high period.
  assign req      = myvalid & ~myvalid_d;
  assign is_run   = (state == ST_RUN);
  assign pop      = req & is_run & ~empty;
  assign under_ev = req & is_run & empty;
  assign fill_req = req & ~is_run;

  always_comb begin
    level_nxt = level;
    unique case ({push, pop})
      2'b10:   level_nxt = level + 1'b1;
      2'b01:   level_nxt = level - 1'b1;
      default: level_nxt = level;
    endcase
  end

  // Muted pops still consume the sample so timing is preserved.
  always_comb begin
    out_nxt = audio_out;
    unique case (1'b1)
      pop:                out_nxt = mute ? '0 : mem[rd_ptr];
      fill_req, under_ev: out_nxt = '0;
      default:            out_nxt = audio_out;
    endcase
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_FILL: begin
        if (level >= LVL_PRE) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (under_ev) begin
          state_nxt = ST_FILL;
        end
      end
      default: state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk_50m) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk_50m or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      state     <= ST_FILL;
      myvalid_d <= 1'b0;
      audio_out <= '0;
      underrun  <= 1'b0;
    end else begin
      myvalid_d <= myvalid;
      level     <= level_nxt;
      state     <= state_nxt;
      audio_out <= out_nxt;
      underrun  <= under_ev;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

`ifdef AUDIO_FIFO_STATS_EN
  logic overrun_ev;

  assign overrun_ev = s_valid & ~s_ready;

  always_ff @(posedge clk_50m or posedge rst_i) begin
    if (rst_i) begin
      underrun_cnt <= '0;
      overrun_cnt  <= '0;
    end else begin
      if (under_ev && underrun_cnt != 16'hFFFF) begin
        underrun_cnt <= underrun_cnt + 1'b1;
      end
      if (overrun_ev && overrun_cnt != 16'hFFFF) begin
        overrun_cnt <= overrun_cnt + 1'b1;
      end
    end
  end
`endif

endmodule
